// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: runtime owner of the UART baud_rate word.
// Takes rate-change requests over valid/ready and range-checks them. Each
// change waits until TX and RX are idle, then the new rate is applied and the
// tick generator gets a restart pulse. When CONFIRM_EN is set, the host must
// confirm inside a window or the previous rate is restored, so a bad rate
// cannot lock out the link.
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_baud/req_ready  rate-change request handshake
//   tx_busy, rx_busy              UART mid-frame indications (sampled in DRAIN)
//   confirm                       host confirmation level (sampled in CONFIRM)
//   baud_rate, gen_rst            active rate and restart to the tick generator
//   busy                          change in progress
//   done, reverted, cfg_err       one-cycle result pulses
module baud_cfg_ctrl #(
  parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
  parameter int unsigned DEFAULT_BAUD    = 115_200,
  parameter int unsigned MIN_BAUD        = 1_200,
  parameter int unsigned MAX_BAUD        = 921_600,
  parameter int unsigned GEN_RST_CYCLES  = 2,
  parameter bit          CONFIRM_EN      = 1'b1,
  parameter int unsigned CONFIRM_TIMEOUT = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_baud,
  output logic        req_ready,
  input  logic        tx_busy,
  input  logic        rx_busy,
  input  logic        confirm,
  output logic [31:0] baud_rate,
  output logic        gen_rst,
  output logic        busy,
  output logic        done,
  output logic        reverted,
  output logic        cfg_err
);

  localparam int unsigned CNT_W = 32;

  localparam logic [CNT_W-1:0] DEF_W    = CNT_W'(DEFAULT_BAUD);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_BAUD);
  localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MAX_BAUD);
  localparam logic [CNT_W-1:0] GEN_LAST = CNT_W'(GEN_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(CONFIRM_TIMEOUT - 1);

  // Parameter sanity checks at elaboration
  if (MAX_BAUD > CLK_FREQ_HZ / 2) begin : g_bad_max_baud
    $error("baud_cfg_ctrl: MAX_BAUD must not exceed CLK_FREQ_HZ/2");
  end
  if (GEN_RST_CYCLES < 1) begin : g_bad_gen_rst
    $error("baud_cfg_ctrl: GEN_RST_CYCLES must be at least 1");
  end
  if (CONFIRM_TIMEOUT < 1) begin : g_bad_timeout
    $error("baud_cfg_ctrl: CONFIRM_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_APPLY   = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_REVERT  = 3'd4
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] pend_baud;
  logic [CNT_W-1:0] prev_baud;
  logic [CNT_W-1:0] gen_cnt;
  logic [CNT_W-1:0] win_cnt;

  // Handshake status decodes straight from the state register
  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;

  // Controller FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_rate <= DEF_W;
      pend_baud <= DEF_W;
      prev_baud <= DEF_W;
      gen_rst   <= 1'b0;
      gen_cnt   <= '0;
      win_cnt   <= '0;
      done      <= 1'b0;
      reverted  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done     <= 1'b0;
      reverted <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if ((req_baud < MIN_W) || (req_baud > MAX_W)) begin
              cfg_err <= 1'b1;
            end else if (req_baud == baud_rate) begin
              // Already running at this rate: acknowledge without a restart
              done <= 1'b1;
            end else begin
              pend_baud <= req_baud;
              prev_baud <= baud_rate;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Switch only between frames on both directions
          if (!tx_busy && !rx_busy) begin
            baud_rate <= pend_baud;
            gen_rst   <= 1'b1;
            gen_cnt   <= '0;
            state     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (gen_cnt == GEN_LAST) begin
            gen_rst <= 1'b0;
            gen_cnt <= '0;
            if (CONFIRM_EN) begin
              win_cnt <= '0;
              state   <= ST_CONFIRM;
            end else begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            gen_cnt <= gen_cnt + CNT_W'(1);
          end
        end
        ST_CONFIRM: begin
          // Confirm takes priority over expiry in the final window cycle
          if (confirm) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (win_cnt == WIN_LAST) begin
            baud_rate <= prev_baud;
            gen_rst   <= 1'b1;
            gen_cnt   <= '0;
            state     <= ST_REVERT;
          end else begin
            win_cnt <= win_cnt + CNT_W'(1);
          end
        end
        ST_REVERT: begin
          if (gen_cnt == GEN_LAST) begin
            gen_rst  <= 1'b0;
            gen_cnt  <= '0;
            reverted <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            gen_cnt <= gen_cnt + CNT_W'(1);
          end
        end
        default: begin
          gen_rst <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
